// File: rtl/systolic_skew_feeder_if.sv
// Operand write port and array-edge outputs of the systolic skew feeder.
// master drives the write/start side, slave is the feeder itself.
interface systolic_skew_feeder_if #(
    parameter int N  = 4,
    parameter int K  = 4,
    parameter int DW = 16
);
    localparam int IW = $clog2((N > K) ? N : K);

    logic            wr_en;
    logic            wr_sel;
    logic [IW-1:0]   wr_row;
    logic [IW-1:0]   wr_col;
    logic [DW-1:0]   wr_data;
    logic            start;
    logic            clr_pe;
    logic [N*DW-1:0] out_W;
    logic [N*DW-1:0] out_N;
    logic            feed_valid;
    logic            busy;
    logic            done;

    modport master (
        output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        input  clr_pe, out_W, out_N, feed_valid, busy, done
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        output clr_pe, out_W, out_N, feed_valid, busy, done
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Buffers A (NxK) and B (KxN) and drives them diagonally skewed onto the
// west/north edges of an NxN systolic array, then flushes and pulses done.
module systolic_skew_feeder #(
    parameter int N  = 4,
    parameter int K  = 4,
    parameter int DW = 16
) (
    input  logic clk,
    input  logic reset,
    systolic_skew_feeder_if.slave bus
);
    localparam int IW = $clog2((N > K) ? N : K);
    localparam int CW = $clog2(K + 2 * N);
    localparam logic [CW-1:0] FEED_LAST  = CW'(K + N - 2);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   a_q [N][K];
    logic [DW-1:0]   b_q [K][N];
    logic            clr_q, fv_q, busy_q, done_q;
    logic [N*DW-1:0] w_q, w_d, n_q, n_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_CLEAR;
            S_CLEAR: state_d = S_FEED;
            S_FEED:  if (cnt_q == FEED_LAST) state_d = S_FLUSH;
                     else cnt_d = cnt_q + 1'b1;
            S_FLUSH: if (cnt_q == FLUSH_LAST) state_d = S_DONE;
                     else cnt_d = cnt_q + 1'b1;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Edges are computed from the next state/index so the registered outputs
    // line up with the state they belong to; row i and column j share t = i + k.
    always_comb begin
        w_d = '0;
        n_d = '0;
        if (state_d == S_FEED) begin
            for (int unsigned i = 0; i < N; i++) begin
                for (int unsigned k = 0; k < K; k++) begin
                    if (cnt_d == CW'(i + k)) begin
                        w_d[i*DW +: DW] = a_q[i][k];
                        n_d[i*DW +: DW] = b_q[k][i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            clr_q   <= 1'b0;
            fv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            w_q     <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clr_q   <= (state_d == S_CLEAR);
            fv_q    <= (state_d == S_FEED);
            busy_q  <= (state_d == S_CLEAR) || (state_d == S_FEED) || (state_d == S_FLUSH);
            done_q  <= (state_d == S_DONE);
            w_q     <= w_d;
            n_q     <= n_d;
        end
    end

    // Operand buffers survive reset; index matching drops out-of-range writes.
    always_ff @(posedge clk) begin
        if (bus.wr_en && !busy_q) begin
            for (int unsigned i = 0; i < N; i++) begin
                for (int unsigned k = 0; k < K; k++) begin
                    if (!bus.wr_sel && bus.wr_row == IW'(i) && bus.wr_col == IW'(k))
                        a_q[i][k] <= bus.wr_data;
                end
            end
            for (int unsigned k = 0; k < K; k++) begin
                for (int unsigned j = 0; j < N; j++) begin
                    if (bus.wr_sel && bus.wr_row == IW'(k) && bus.wr_col == IW'(j))
                        b_q[k][j] <= bus.wr_data;
                end
            end
        end
    end

    assign bus.clr_pe     = clr_q;
    assign bus.feed_valid = fv_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.out_W      = w_q;
    assign bus.out_N      = n_q;
endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Edge driver for the N×N systolic array of P_Element tiles. It buffers an N×K operand matrix A and a K×N operand matrix B through a simple write port. On `start` it clears the array accumulators, then injects A rows onto the west edge and B columns onto the north edge with the diagonal skew the array needs. It then flushes with zeros until every PE holds its final dot product, and signals completion with `done`.

## Interface
- `N`, 4, array dimension (rows = columns), N ≥ 2
- `K`, 4, inner dimension (length of each dot product), K ≥ 2
- `DW`, 16, operand width; matches PE `in_N`/`in_W`
- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  operand buffer write strobe
- `wr_sel`  in  1  0 = write A, 1 = write B
- `wr_row`  in  $clog2(max(N,K))  A: row i (< N); B: row k (< K)
- `wr_col`  in  $clog2(max(N,K))  A: column k (< K); B: column j (< N)
- `wr_data`  in  DW  operand value
- `start`  in  1  begin a run (sampled only in IDLE)
- `clr_pe`  out  1  PE accumulator clear, active-high, wired to every PE reset
- `out_W`  out  N*DW  west-edge operands; row i on bits [i*DW +: DW]
- `out_N`  out  N*DW  north-edge operands; column j on bits [j*DW +: DW]
- `feed_valid`  out  1  high during FEED cycles
- `busy`  out  1  high from CLEAR through FLUSH
- `done`  out  1  one-cycle completion pulse

## Operation
- The operand buffers are plain registers, N*K entries each, and are not cleared by reset.
- Writes:
  - A write stores A[wr_row][wr_col] when `wr_sel`=0.
  - A write stores B[wr_row][wr_col] when `wr_sel`=1.
  - Out-of-range indices are dropped.
  - `wr_en` is ignored while `busy`=1.
- FSM states: IDLE → CLEAR → FEED → FLUSH → DONE → IDLE.
- IDLE: all outputs 0. When `start`=1, go to CLEAR. A `start` seen in any other state is ignored (no queuing).
- CLEAR: 1 cycle with `clr_pe`=1, `busy`=1, edges 0.
- FEED: K+N-1 cycles, with cycle index t = 0 … K+N-2.
  - West row i carries A[i][t−i] if 0 ≤ t−i < K, else 0.
  - North column j carries B[t−j][j] if 0 ≤ t−j < K, else 0.
  - `feed_valid`=1 throughout FEED.
- FLUSH: N cycles with both edges 0 and `feed_valid`=0. This covers the N−1 cycles of diagonal propagation plus one accumulate cycle.
- DONE: 1 cycle with `done`=1 and `busy`=0. Then return to IDLE.
- A single counter of width $clog2(K+2N) tracks the FEED and FLUSH indices. It resets to 0 on every state entry.
- Edge outputs are zero-padded and never sign-manipulated; the PE does the arithmetic.

## Timing
- Reset values (on `reset`=0, asynchronous): state=IDLE, counter=0, `clr_pe`=`feed_valid`=`busy`=`done`=0, `out_W`=`out_N`=0.
- All outputs are registered and change only on `clk` rising edges, except during asynchronous reset.
- If `start` is sampled at edge e0:
  - CLEAR occupies the cycle after e0.
  - FEED t=0 follows it.
  - `done` is high in cycle 1+(K+N−1)+N+1 after e0, which is cycle 13 for N=K=4.
- A write and `start` in the same IDLE cycle: the write lands. The buffers are first read in FEED, so the new value is used.
- Reset mid-run: outputs go to 0 immediately, the FSM returns to IDLE, no `done` pulse is produced, and the buffers are retained.
- Back-to-back runs: a `start` held high through DONE is ignored in DONE. A `start` sampled in the following IDLE cycle launches a new run.

## Test plan
- Reset: drive `reset`=0 mid-FEED at N=K=4 → all outputs 0 in the same cycle. After release, the FSM sits in IDLE and `done` never pulses.
- Skew pattern, N=K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]]:
  - `out_W` row0 must be 1,2,0 and row1 must be 0,3,4 over FEED t=0..2.
  - `out_N` col0 must be 5,7,0 and col1 must be 0,6,8.
  - `clr_pe` is high for exactly 1 cycle before FEED.
  - `done` is high in the 7th cycle after the start edge.
- End-to-end: the same stimulus with a 2×2 P_Element array attached → PE outputs read 19, 22, 43, 50 in the cycle `done`=1.
- Start/write interaction:
  - `start` pulsed during FEED → ignored; the cycle count is unchanged.
  - `wr_en` during `busy` → the buffer is unchanged on the next run.
  - A write with `start` in the same IDLE cycle → the new value appears on the edge.
- Default size N=K=4, A=identity, B[k][j]=k*4+j+1 → array results equal B. FEED lasts 7 cycles, FLUSH lasts 4, and `done` is high in cycle 13.
- Back-to-back runs: two runs with different B and `start` reasserted in the IDLE cycle after DONE → the second run's results are correct, and the PEs were cleared by the second `clr_pe` pulse.
